// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the EX stage and the iterative multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/iter_muldiv_unit.sv
// iter_muldiv_unit: one-bit-per-clock shift-add multiply / restoring divide into HI/LO; define MULDIV_MADD_EN for MADD/MADDU accumulate.
module iter_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    muldiv_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_n;

    logic             div_q, neg_q, rem_neg_q, dz_q;
    logic [WIDTH-1:0] m_q, r_q, q_q;
    logic [CW-1:0]    cnt;
`ifdef MULDIV_MADD_EN
    logic             acc_q;
`endif

    logic               legal, op_signed, op_div, b_zero, accept;
    logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix, res;

`ifdef MULDIV_MADD_EN
    assign legal = bus.op <= 3'd5;
`else
    assign legal = bus.op <= 3'd3;
`endif
    assign op_signed = ~bus.op[0];
    assign op_div    = bus.op[2:1] == 2'b01;
    assign b_zero    = bus.b == '0;
    assign accept    = state == IDLE && bus.start && !bus.flush && legal;
    assign a_mag     = (op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag     = (op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // r_q:q_q is the running product (multiply) or remainder:quotient (divide)
    assign mul_sum  = {1'b0, r_q} + (q_q[0] ? {1'b0, m_q} : '0);
    assign div_sh   = {r_q, q_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, m_q};

    // signs are restored after the magnitude iteration; MIN/-1 wraps back to MIN naturally
    assign prod     = {r_q, q_q};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = neg_q ? -q_q : q_q;
    assign rem_fix  = rem_neg_q ? -r_q : r_q;
`ifdef MULDIV_MADD_EN
    assign res = dz_q ? {q_q, {WIDTH{1'b1}}} : div_q ? {rem_fix, quo_fix} :
                 acc_q ? {bus.hi, bus.lo} + prod_fix : prod_fix;
`else
    assign res = dz_q ? {q_q, {WIDTH{1'b1}}} : div_q ? {rem_fix, quo_fix} : prod_fix;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // next state: flush always returns to IDLE, divide by zero skips RUN
    always_comb begin
        state_n = state;
        if (bus.flush)          state_n = IDLE;
        else if (state == IDLE) state_n = accept ? ((op_div && b_zero) ? FIX : RUN) : IDLE;
        else if (state == RUN)  state_n = (cnt == LAST) ? FIX : RUN;
        else                    state_n = IDLE;
    end

    // operand capture, one iteration per RUN cycle, result write and done pulse in FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q           <= 1'b0;
            neg_q           <= 1'b0;
            rem_neg_q       <= 1'b0;
            dz_q            <= 1'b0;
            m_q             <= '0;
            r_q             <= '0;
            q_q             <= '0;
            cnt             <= '0;
`ifdef MULDIV_MADD_EN
            acc_q           <= 1'b0;
`endif
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.hi          <= '0;
            bus.lo          <= '0;
            bus.div_by_zero <= 1'b0;
        end else if (accept) begin
            div_q           <= op_div;
            neg_q           <= op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            rem_neg_q       <= op_signed & bus.a[WIDTH-1];
            dz_q            <= op_div & b_zero;
            m_q             <= b_mag;
            q_q             <= (op_div && b_zero) ? bus.a : a_mag;
            r_q             <= '0;
            cnt             <= '0;
`ifdef MULDIV_MADD_EN
            acc_q           <= bus.op[2];
`endif
            bus.busy        <= 1'b1;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else if (bus.flush || state == IDLE) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else if (state == RUN) begin
            r_q <= div_q ? (div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0]) : mul_sum[WIDTH:1];
            q_q <= div_q ? {q_q[WIDTH-2:0], ~div_diff[WIDTH]} : {mul_sum[0], q_q[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
        end else begin
            {bus.hi, bus.lo} <= res;
            bus.div_by_zero  <= dz_q;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b1;
        end
    end
endmodule

// File: tb/tb_iter_muldiv_unit.sv
// tb_iter_muldiv_unit: vector table plus random model checks through a scoreboard, with flush/reset/ignore sequences.
module tb_iter_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus();
    iter_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b, hi, lo;
        logic         dz;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi, lo;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];
    int total = 0;
    int bad = 0;
    logic [W-1:0] last_hi = '0, last_lo = '0;
    logic last_dz = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sbv;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        p = '0;
        case (op)
            3'd0: p = 64'(sa * sbv);
            3'd1: p = {32'b0, a} * {32'b0, b};
            3'd2: begin p[31:0] = 32'(sa / sbv); p[63:32] = 32'(sa % sbv); end
            default: begin p[31:0] = a / b; p[63:32] = a % b; end
        endcase
        return p;
    endfunction

    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz);
        exp_t e, got;
        int n;
        e.hi = eh; e.lo = el; e.dz = edz;
        e.lat = (op[2:1] == 2'b01 && b == '0) ? 2 : W + 2;
        sb.push_back(e);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        n = 0;
        do begin
            tick();
            n++;
            bus.start = 1'b0;
            if (n == 1) check({name, " busy"}, 64'(bus.busy), 64'd1);
        end while (!bus.done && n < 60);
        got = sb.pop_front();
        if (!bus.done) begin
            total++;
            bad++;
            $display("FAIL %s timeout: no done after %0d cycles, required %0d", name, n, got.lat);
        end else begin
            check({name, " latency"}, 64'(n), 64'(got.lat));
            check({name, " hi"}, 64'(bus.hi), 64'(got.hi));
            check({name, " lo"}, 64'(bus.lo), 64'(got.lo));
            check({name, " dz"}, 64'(bus.div_by_zero), 64'(got.dz));
        end
        last_hi = got.hi; last_lo = got.lo; last_dz = got.dz;
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.done) seen++;
        end
        check({name, " no done"}, 64'(seen), 64'd0);
        check({name, " idle busy"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic flush_at(input string name, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        int seen;
        seen = 0;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        for (int n = 1; n <= k; n++) begin
            tick();
            bus.start = 1'b0;
            if (bus.done) seen++;
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        if (bus.done) seen++;
        check({name, " busy after flush"}, 64'(bus.busy), 64'd0);
        check({name, " done during flush"}, 64'(seen), 64'd0);
        watch_no_done(name, 40);
        check({name, " hi kept"}, 64'(bus.hi), 64'(last_hi));
        check({name, " lo kept"}, 64'(bus.lo), 64'(last_lo));
        check({name, " dz kept"}, 64'(bus.div_by_zero), 64'(last_dz));
    endtask

    initial begin
        logic [63:0] p;
        logic [2:0] rop;
        logic [W-1:0] ra, rb;
        int n;

        vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'h2,        32'h1,        32'hFFFFFFFE, 1'b0};
        vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{3'd3, 32'h7,        32'h2,        32'h1,        32'h3,        1'b0};
        vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0};
        vecs[5]  = '{3'd2, 32'h5,        32'h0,        32'h5,        32'hFFFFFFFF, 1'b1};
        vecs[6]  = '{3'd1, 32'h3,        32'h4,        32'h0,        32'hC,        1'b0};
        vecs[7]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0};
        vecs[8]  = '{3'd3, 32'hFFFFFFFF, 32'h1,        32'h0,        32'hFFFFFFFF, 1'b0};
        vecs[9]  = '{3'd2, 32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 1'b0};
        vecs[10] = '{3'd3, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[11] = '{3'd0, 32'h5,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0};

        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
        tick();
        tick();
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset hi", 64'(bus.hi), 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);
        check("reset dz", 64'(bus.div_by_zero), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);
        tick();
        check("done single pulse", 64'(bus.done), 64'd0);

        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (rb == '0) rb = 32'h3;
            p = model(rop, ra, rb);
            run_op($sformatf("rand%0d", i), rop, ra, rb, p[63:32], p[31:0], 1'b0);
        end

        run_op("dz set", 3'd2, 32'h5, 32'h0, 32'h5, 32'hFFFFFFFF, 1'b1);
        run_op("dz clear", 3'd1, 32'h6, 32'h7, 32'h0, 32'h2A, 1'b0);

        flush_at("flush run", 3'd1, 32'h9, 32'h9, 10);
        flush_at("flush fix", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        flush_at("flush div0 fix", 3'd2, 32'h5, 32'h0, 1);

        bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'h9; bus.b = 32'h9; bus.flush = 1'b1;
        tick();
        bus.start = 1'b0; bus.flush = 1'b0;
        check("idle flush drops start", 64'(bus.busy), 64'd0);
        watch_no_done("idle flush", 40);

        bus.start = 1'b1; bus.op = 3'd7; bus.a = 32'h2; bus.b = 32'h3;
        tick();
        bus.start = 1'b0;
        check("illegal 111 busy", 64'(bus.busy), 64'd0);
        watch_no_done("illegal 111", 5);
`ifndef MULDIV_MADD_EN
        bus.start = 1'b1; bus.op = 3'd5;
        tick();
        bus.start = 1'b0;
        check("illegal 101 busy", 64'(bus.busy), 64'd0);
        watch_no_done("illegal 101", 40);
`endif

        bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'h3; bus.b = 32'h5;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n++;
            bus.start = 1'b0;
        end
        bus.start = 1'b1; bus.a = 32'h7; bus.b = 32'h7;
        tick();
        n++;
        bus.start = 1'b0;
        while (!bus.done && n < 60) begin
            tick();
            n++;
        end
        check("busy start latency", 64'(n), 64'(W + 2));
        check("busy start hi", 64'(bus.hi), 64'd0);
        check("busy start lo", 64'(bus.lo), 64'hF);
        last_hi = 32'h0; last_lo = 32'hF; last_dz = 1'b0;
        watch_no_done("busy start ignored", 40);

        bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", 64'(bus.busy), 64'd0);
        check("async rst done", 64'(bus.done), 64'd0);
        check("async rst hi", 64'(bus.hi), 64'd0);
        check("async rst lo", 64'(bus.lo), 64'd0);
        check("async rst dz", 64'(bus.div_by_zero), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_op("after reset", 3'd3, 32'h64, 32'h7, 32'h2, 32'hE, 1'b0);

`ifdef MULDIV_MADD_EN
        run_op("madd seed", 3'd1, 32'h5, 32'h1, 32'h0, 32'h5, 1'b0);
        run_op("maddu", 3'd5, 32'h2, 32'h3, 32'h0, 32'hB, 1'b0);
        run_op("madd signed", 3'd4, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h9, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
